// File: rtl/dmem_pkg.sv
// Shared widths, write-buffer entry type and byte-mask helper for the data-memory port.
package dmem_pkg;

  localparam int unsigned DATA_W = 2 ** 5;
  localparam int unsigned BYTES  = DATA_W / 8;
  localparam int unsigned ADDR_W = 12;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [BYTES-1:0]  mask;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic [DATA_W-1:0] mask_expand(input logic [BYTES-1:0] be);
    logic [DATA_W-1:0] bits;
    bits = '0;
    for (int b = 0; b < int'(BYTES); b++) begin
      bits[8*b +: 8] = {8{be[b]}};
    end
    return bits;
  endfunction

endpackage

// File: rtl/dmem_wbuf.sv
// In-order store write buffer: circular FIFO, per-entry address match and, when
// DMEM_FWD_EN is defined, the oldest-to-youngest store-to-load forwarding merge.
module dmem_wbuf
  import dmem_pkg::*;
#(
  parameter int unsigned CACHE_DEEPTHE = ADDR_W,
  parameter int unsigned WB_DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [CACHE_DEEPTHE-1:0]   push_addr_i,
  input  logic [BYTES-1:0]           push_mask_i,
  input  logic [DATA_W-1:0]          push_data_i,
  input  logic                       pop_i,
  input  logic [CACHE_DEEPTHE-1:0]   lookup_addr_i,
  output logic [$clog2(WB_DEPTH):0]  count_o,
  output logic [CACHE_DEEPTHE-1:0]   head_addr_o,
  output logic [BYTES-1:0]           head_mask_o,
`ifdef DMEM_FWD_EN
  output logic [DATA_W-1:0]          head_data_o,
  output logic [BYTES-1:0]           fwd_mask_o,
  output logic [DATA_W-1:0]          fwd_data_o
`else
  output logic [DATA_W-1:0]          head_data_o,
  output logic                       hit_o
`endif
);

  localparam int unsigned PtrW = $clog2(WB_DEPTH);

  wb_entry_t           mem_q [WB_DEPTH];
  logic [PtrW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [PtrW:0]       count_q, count_d;
  logic [WB_DEPTH-1:0] match;

  always_comb begin
    head_d  = pop_i ? head_q + 1'b1 : head_q;
    tail_d  = push_i ? tail_q + 1'b1 : tail_q;
    count_d = count_q + (PtrW+1)'(push_i) - (PtrW+1)'(pop_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries outside the valid window are never read.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[tail_q] <= wb_entry_t'{addr: ADDR_W'(push_addr_i), mask: push_mask_i,
                                   data: push_data_i};
    end
  end

  // An entry is live when its distance from head is below count.
  always_comb begin
    match = '0;
    for (int i = 0; i < int'(WB_DEPTH); i++) begin
      match[i] = ({1'b0, PtrW'(PtrW'(i) - head_q)} < count_q) &&
                 (mem_q[i].addr == ADDR_W'(lookup_addr_i));
    end
  end

  assign count_o     = count_q;
  assign head_addr_o = CACHE_DEEPTHE'(mem_q[head_q].addr);
  assign head_mask_o = mem_q[head_q].mask;
  assign head_data_o = mem_q[head_q].data;

`ifdef DMEM_FWD_EN
  logic [PtrW-1:0] idx;

  // Walk from head so younger stores overwrite older bytes.
  always_comb begin
    fwd_mask_o = '0;
    fwd_data_o = '0;
    idx        = '0;
    for (int k = 0; k < int'(WB_DEPTH); k++) begin
      idx = head_q + PtrW'(k);
      if (match[idx]) begin
        for (int b = 0; b < int'(BYTES); b++) begin
          if (mem_q[idx].mask[b]) begin
            fwd_mask_o[b]         = 1'b1;
            fwd_data_o[8*b +: 8]  = mem_q[idx].data[8*b +: 8];
          end
        end
      end
    end
  end
`else
  assign hit_o = |match;
`endif

endmodule

// File: rtl/dmem_port.sv
// Data-memory port: load/store handshake, load-over-drain SRAM arbitration and load response.
// Define DMEM_FWD_EN for store-to-load forwarding; otherwise matching loads wait for the drain.
module dmem_port
  import dmem_pkg::*;
#(
  parameter int unsigned CACHE_WIDTHE  = 5,
  parameter int unsigned CACHE_DEEPTHE = 12,
  parameter int unsigned WB_DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          iReqValid,
  output logic                          oReqReady,
  input  logic                          iReqWr,
  input  logic [CACHE_DEEPTHE-1:0]      iReqAddr,
  input  logic [2**CACHE_WIDTHE/8-1:0]  iReqMask,
  input  logic [2**CACHE_WIDTHE-1:0]    iReqData,
  output logic                          oRdValid,
  output logic [2**CACHE_WIDTHE-1:0]    oRdData,
  output logic                          oSramEn,
  output logic                          oSramWe,
  output logic [CACHE_DEEPTHE-1:0]      oSramAddr,
  output logic [2**CACHE_WIDTHE-1:0]    oSramMask,
  output logic [2**CACHE_WIDTHE-1:0]    oSramWdata,
  input  logic [2**CACHE_WIDTHE-1:0]    iSramRdata,
  output logic                          oWbEmpty
);

  localparam int unsigned CntW = $clog2(WB_DEPTH) + 1;

  logic [CntW-1:0]          count;
  logic [CACHE_DEEPTHE-1:0] head_addr;
  logic [BYTES-1:0]         head_mask;
  logic [DATA_W-1:0]        head_data;
  logic                     wb_full, load_ok, accept, load_acc, store_acc, drain;
  logic                     rd_valid_q;
  logic                     wb_empty_q, wb_empty_d;

`ifdef DMEM_FWD_EN
  logic [BYTES-1:0]  fwd_mask, fwd_mask_q;
  logic [DATA_W-1:0] fwd_data, fwd_data_q, fwd_bits;
`else
  logic              hit;
`endif

  dmem_wbuf #(
    .CACHE_DEEPTHE (CACHE_DEEPTHE),
    .WB_DEPTH      (WB_DEPTH)
  ) u_wbuf (
    .clk           (clk),
    .rst           (rst),
    .push_i        (store_acc),
    .push_addr_i   (iReqAddr),
    .push_mask_i   (iReqMask),
    .push_data_i   (iReqData),
    .pop_i         (drain),
    .lookup_addr_i (iReqAddr),
    .count_o       (count),
    .head_addr_o   (head_addr),
    .head_mask_o   (head_mask),
`ifdef DMEM_FWD_EN
    .head_data_o   (head_data),
    .fwd_mask_o    (fwd_mask),
    .fwd_data_o    (fwd_data)
`else
    .head_data_o   (head_data),
    .hit_o         (hit)
`endif
  );

  assign wb_full = (count == CntW'(WB_DEPTH));

`ifdef DMEM_FWD_EN
  assign load_ok = 1'b1;
`else
  assign load_ok = ~hit;
`endif

  always_comb begin
    oReqReady  = 1'b0;
    oSramEn    = 1'b0;
    oSramWe    = 1'b0;
    oSramAddr  = '0;
    oSramMask  = '0;
    oSramWdata = '0;
    if (!rst) begin
      oReqReady = iReqWr ? ~wb_full : load_ok;
    end
    accept    = iReqValid & oReqReady;
    load_acc  = accept & ~iReqWr;
    store_acc = accept & iReqWr;
    // A full buffer cannot accept a store, so it always frees a slot on a load-free cycle.
    drain     = ~load_acc & (count != '0) & (wb_full | ~accept);
    if (load_acc) begin
      oSramEn   = 1'b1;
      oSramAddr = iReqAddr;
    end else if (drain) begin
      oSramEn    = 1'b1;
      oSramWe    = 1'b1;
      oSramAddr  = head_addr;
      oSramMask  = mask_expand(head_mask);
      oSramWdata = head_data;
    end
    wb_empty_d = ~store_acc & ((count == '0) | ((count == CntW'(1)) & drain));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      wb_empty_q <= 1'b1;
    end else begin
      rd_valid_q <= load_acc;
      wb_empty_q <= wb_empty_d;
    end
  end

`ifdef DMEM_FWD_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_mask_q <= '0;
      fwd_data_q <= '0;
    end else if (load_acc) begin
      fwd_mask_q <= fwd_mask;
      fwd_data_q <= fwd_data;
    end
  end

  assign fwd_bits = mask_expand(fwd_mask_q);
  assign oRdData  = rd_valid_q ? ((iSramRdata & ~fwd_bits) | (fwd_data_q & fwd_bits)) : '0;
`else
  assign oRdData  = rd_valid_q ? iSramRdata : '0;
`endif

  assign oRdValid = rd_valid_q;
  assign oWbEmpty = wb_empty_q;

endmodule
